reservation_station: RTL and testbench
======================================

# reservation_station

Buffers instructions issued with renamed operands (q/v pairs from operand routing) and holds each one until both source values are known. It snoops the common data bus (CDB) to capture results tagged with pending ROB tags, then dispatches ready entries to a single functional unit over a valid/ready handshake. It sits between the issue/operand-routing stage and a functional unit; its operand inputs are the consumer side of the operand-routing outputs.

## Interface

- XLEN, 32, datapath width
- ROB_TAG_WIDTH, 4, ROB tag width
- RS_SIZE, 4, number of entries (power of two, ≥2)
- CONTROL_WIDTH, 8, opaque FU control bits carried per entry

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- flush  input  1  synchronous invalidate of all entries
- issue_enable  input  1  write a new entry this cycle
- issue_control  input  CONTROL_WIDTH  FU control for the entry
- issue_rob_tag  input  ROB_TAG_WIDTH  destination ROB tag
- q1_valid, q2_valid  input  1 each  operand still pending when 1
- q1, q2  input  ROB_TAG_WIDTH each  producer tag of pending operand
- v1, v2  input  XLEN each  operand value, used when q*_valid=0
- rs_full  output  1  all entries busy; issue_enable ignored
- cdb_valid  input  1  broadcast present
- cdb_rob_tag  input  ROB_TAG_WIDTH  broadcast tag
- cdb_data  input  XLEN  broadcast value
- dispatch_valid  output  1  an entry is ready
- dispatch_ready  input  1  FU accepts this cycle
- dispatch_control  output  CONTROL_WIDTH  selected entry control
- dispatch_rob_tag  output  ROB_TAG_WIDTH  selected entry tag
- dispatch_v1, dispatch_v2  output  XLEN each  selected entry operands

## Operation

- Entry state: busy, control, rob_tag, and per operand {pending, tag, value}.
- Issue: when issue_enable=1 and rs_full=0, write lowest-index non-busy entry; busy←1. Issue while rs_full=1 is dropped, no state change.
- Issue/CDB bypass: if cdb_valid=1 and q*_valid=1 with q*==cdb_rob_tag in the issuing cycle, the entry stores cdb_data for that operand with pending=0.
- CDB capture: every busy entry with pending operand whose tag==cdb_rob_tag (cdb_valid=1) stores cdb_data, pending←0. Multiple entries/both operands may capture in the same cycle.
- Ready: busy and both operands not pending (registered state only; capture this cycle counts next cycle).
- Select: lowest-index ready entry drives dispatch_*. dispatch_valid = any ready.
- Dispatch: on dispatch_valid && dispatch_ready, selected entry busy←0 at the edge.
- Dispatch and issue same cycle: rs_full is from registered busy, so the freed slot is not reusable until next cycle; if not full, issue uses lowest free slot excluding the dispatching one.
- flush: all busy←0 at edge; overrides issue, CDB capture and dispatch in that cycle.
- reset: same effect as flush; overrides everything.
- rs_full = all entries busy (combinational from registered state).

## Timing

- Reset values: all busy=0; rs_full=0; dispatch_valid=0; dispatch_control, dispatch_rob_tag, dispatch_v1, dispatch_v2 = 0.
- All dispatch_* data outputs are 0 whenever dispatch_valid=0.
- Issue with both operands ready (or bypassed) at edge N → dispatch_valid=1 in cycle N+1 (1-cycle latency), assuming no older-index ready entry.
- CDB capture at edge N completing an entry → dispatch_valid for it in cycle N+1.
- dispatch_* held stable while dispatch_valid=1 and dispatch_ready=0, unless a lower-index entry becomes ready (selection may change; FU must sample only on handshake).
- No combinational path from cdb_* or issue_* to dispatch_*; dispatch_ready affects only next state.

## Test plan

- Reset then issue tag 3, v1=0x11, v2=0x22, both ready, dispatch_ready=1 → next cycle dispatch_valid=1, rob_tag=3, v1=0x11, v2=0x22; following cycle dispatch_valid=0, rs_full=0.
- Issue tag 5 with q1_valid=1, q1=2; CDB tag 2 data 0xCAFE_CAFE two cycles later → dispatch_valid low until cycle after CDB, then v1=0xCAFE_CAFE.
- Issue with q2=7 pending while cdb_valid=1, cdb_rob_tag=7, cdb_data=0xDEAD_BEEF same cycle → next cycle dispatch_valid=1, v2=0xDEAD_BEEF.
- Fill 4 entries with pending operands → rs_full=1; 5th issue dropped; one CDB completing entry 2, dispatch_ready=1 → entry 2 dispatched, rs_full=0 the cycle after.
- Two ready entries (idx 0 tag 1, idx 1 tag 4), dispatch_ready=0 for 3 cycles → tag 1 held stable; then ready=1 → tag 1 then tag 4 on consecutive cycles.
- Entries busy, assert flush with simultaneous issue and CDB → next cycle all empty, dispatch_valid=0, rs_full=0, issued entry absent.

Source files
------------

// File: rtl/reservation_station_if.sv
// Issue, CDB and dispatch signal bundle between operand routing, the
// reservation station and its functional unit.
interface reservation_station_if #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ROB_TAG_WIDTH = 4,
    parameter int unsigned CONTROL_WIDTH = 8
);
    logic                     issue_enable;
    logic [CONTROL_WIDTH-1:0] issue_control;
    logic [ROB_TAG_WIDTH-1:0] issue_rob_tag;
    logic                     q1_valid;
    logic                     q2_valid;
    logic [ROB_TAG_WIDTH-1:0] q1;
    logic [ROB_TAG_WIDTH-1:0] q2;
    logic [XLEN-1:0]          v1;
    logic [XLEN-1:0]          v2;
    logic                     rs_full;

    logic                     cdb_valid;
    logic [ROB_TAG_WIDTH-1:0] cdb_rob_tag;
    logic [XLEN-1:0]          cdb_data;

    logic                     dispatch_valid;
    logic                     dispatch_ready;
    logic [CONTROL_WIDTH-1:0] dispatch_control;
    logic [ROB_TAG_WIDTH-1:0] dispatch_rob_tag;
    logic [XLEN-1:0]          dispatch_v1;
    logic [XLEN-1:0]          dispatch_v2;

    // Reservation-station side.
    modport slave (
        input  issue_enable, issue_control, issue_rob_tag,
        input  q1_valid, q2_valid, q1, q2, v1, v2,
        output rs_full,
        input  cdb_valid, cdb_rob_tag, cdb_data,
        output dispatch_valid,
        input  dispatch_ready,
        output dispatch_control, dispatch_rob_tag, dispatch_v1, dispatch_v2
    );

    // Issue stage / CDB / functional-unit side.
    modport master (
        output issue_enable, issue_control, issue_rob_tag,
        output q1_valid, q2_valid, q1, q2, v1, v2,
        input  rs_full,
        output cdb_valid, cdb_rob_tag, cdb_data,
        input  dispatch_valid,
        output dispatch_ready,
        input  dispatch_control, dispatch_rob_tag, dispatch_v1, dispatch_v2
    );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: holds issued instructions until both operands are
// known (snooping the CDB) and dispatches the lowest-index ready entry.
module reservation_station #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ROB_TAG_WIDTH = 4,
    parameter int unsigned RS_SIZE       = 4,
    parameter int unsigned CONTROL_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    reservation_station_if.slave  rs
);
    localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic                     busy;
        logic [CONTROL_WIDTH-1:0] control;
        logic [ROB_TAG_WIDTH-1:0] rob_tag;
        logic                     p1;
        logic [ROB_TAG_WIDTH-1:0] q1;
        logic [XLEN-1:0]          v1;
        logic                     p2;
        logic [ROB_TAG_WIDTH-1:0] q2;
        logic [XLEN-1:0]          v2;
    } entry_t;

    entry_t             entry_q [RS_SIZE];
    entry_t             entry_d [RS_SIZE];
    entry_t             new_entry;
    entry_t             sel_entry;
    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   free_idx;
    logic               any_ready;
    logic               full;
    logic               bypass1;
    logic               bypass2;

    // Readiness, oldest-index select and free-slot search from registered state only.
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        sel_idx   = '0;
        free_idx  = '0;
        any_ready = 1'b0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            busy_vec[i]  = entry_q[i].busy;
            ready_vec[i] = entry_q[i].busy && !entry_q[i].p1 && !entry_q[i].p2;
        end
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel_idx   = IDX_W'(i);
                any_ready = 1'b1;
            end
            if (!busy_vec[i]) begin
                free_idx = IDX_W'(i);
            end
        end
        full = &busy_vec;
    end

    // Incoming entry, with operands completed by a same-cycle CDB broadcast.
    always_comb begin
        bypass1 = rs.cdb_valid && rs.q1_valid && (rs.q1 == rs.cdb_rob_tag);
        bypass2 = rs.cdb_valid && rs.q2_valid && (rs.q2 == rs.cdb_rob_tag);
        new_entry         = '0;
        new_entry.busy    = 1'b1;
        new_entry.control = rs.issue_control;
        new_entry.rob_tag = rs.issue_rob_tag;
        new_entry.p1      = rs.q1_valid && !bypass1;
        new_entry.q1      = rs.q1;
        new_entry.v1      = bypass1 ? rs.cdb_data : rs.v1;
        new_entry.p2      = rs.q2_valid && !bypass2;
        new_entry.q2      = rs.q2;
        new_entry.v2      = bypass2 ? rs.cdb_data : rs.v2;
    end

    // Next state: CDB capture, dispatch retire, issue write, then flush.
    always_comb begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            entry_d[i] = entry_q[i];
            if (entry_q[i].busy && rs.cdb_valid) begin
                if (entry_q[i].p1 && (entry_q[i].q1 == rs.cdb_rob_tag)) begin
                    entry_d[i].p1 = 1'b0;
                    entry_d[i].v1 = rs.cdb_data;
                end
                if (entry_q[i].p2 && (entry_q[i].q2 == rs.cdb_rob_tag)) begin
                    entry_d[i].p2 = 1'b0;
                    entry_d[i].v2 = rs.cdb_data;
                end
            end
        end
        if (any_ready && rs.dispatch_ready) begin
            entry_d[sel_idx].busy = 1'b0;
        end
        // free_idx is never the dispatching slot: that slot is still busy in registered state.
        if (rs.issue_enable && !full) begin
            entry_d[free_idx] = new_entry;
        end
        if (flush) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                entry_d[i].busy = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign sel_entry           = entry_q[sel_idx];
    assign rs.rs_full          = full;
    assign rs.dispatch_valid   = any_ready;
    assign rs.dispatch_control = any_ready ? sel_entry.control : '0;
    assign rs.dispatch_rob_tag = any_ready ? sel_entry.rob_tag : '0;
    assign rs.dispatch_v1      = any_ready ? sel_entry.v1      : '0;
    assign rs.dispatch_v2      = any_ready ? sel_entry.v2      : '0;
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: issue, CDB capture/bypass,
// full handling, ordered dispatch with back-pressure, and flush.
module tb_reservation_station;
    logic clk;
    logic reset;
    logic flush;
    int   tests_run;
    int   tests_failed;

    reservation_station_if #(.XLEN(32), .ROB_TAG_WIDTH(4), .CONTROL_WIDTH(8)) rs_bus ();

    reservation_station #(
        .XLEN(32), .ROB_TAG_WIDTH(4), .RS_SIZE(4), .CONTROL_WIDTH(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .rs    (rs_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs_bus.issue_enable  = 1'b0;
        rs_bus.issue_control = '0;
        rs_bus.issue_rob_tag = '0;
        rs_bus.q1_valid      = 1'b0;
        rs_bus.q2_valid      = 1'b0;
        rs_bus.q1            = '0;
        rs_bus.q2            = '0;
        rs_bus.v1            = '0;
        rs_bus.v2            = '0;
        rs_bus.cdb_valid     = 1'b0;
        rs_bus.cdb_rob_tag   = '0;
        rs_bus.cdb_data      = '0;
    endtask

    task automatic issue(input logic [7:0] ctrl, input logic [3:0] tag,
                         input logic qv1, input logic [3:0] qt1, input logic [31:0] val1,
                         input logic qv2, input logic [3:0] qt2, input logic [31:0] val2);
        rs_bus.issue_enable  = 1'b1;
        rs_bus.issue_control = ctrl;
        rs_bus.issue_rob_tag = tag;
        rs_bus.q1_valid      = qv1;
        rs_bus.q1            = qt1;
        rs_bus.v1            = val1;
        rs_bus.q2_valid      = qv2;
        rs_bus.q2            = qt2;
        rs_bus.v2            = val2;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
        rs_bus.cdb_valid   = 1'b1;
        rs_bus.cdb_rob_tag = tag;
        rs_bus.cdb_data    = data;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        flush        = 1'b0;
        rs_bus.dispatch_ready = 1'b0;
        idle_inputs();
        repeat (2) tick();
        reset = 1'b0;

        check("reset_full",  64'(rs_bus.rs_full), 64'd0);
        check("reset_valid", 64'(rs_bus.dispatch_valid), 64'd0);
        check("reset_tag",   64'(rs_bus.dispatch_rob_tag), 64'd0);
        check("reset_v1",    64'(rs_bus.dispatch_v1), 64'd0);
        check("reset_ctrl",  64'(rs_bus.dispatch_control), 64'd0);

        // Both operands ready: one-cycle latency, then retired.
        rs_bus.dispatch_ready = 1'b1;
        issue(8'hA5, 4'd3, 1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'h22);
        tick();
        idle_inputs();
        check("rdy_valid", 64'(rs_bus.dispatch_valid), 64'd1);
        check("rdy_tag",   64'(rs_bus.dispatch_rob_tag), 64'd3);
        check("rdy_v1",    64'(rs_bus.dispatch_v1), 64'h11);
        check("rdy_v2",    64'(rs_bus.dispatch_v2), 64'h22);
        check("rdy_ctrl",  64'(rs_bus.dispatch_control), 64'hA5);
        tick();
        check("rdy_gone",  64'(rs_bus.dispatch_valid), 64'd0);
        check("rdy_full",  64'(rs_bus.rs_full), 64'd0);
        check("rdy_zero_v1", 64'(rs_bus.dispatch_v1), 64'd0);

        // Pending operand completed by a later CDB broadcast.
        issue(8'h01, 4'd5, 1'b1, 4'd2, 32'h0, 1'b0, 4'd0, 32'h33);
        tick();
        idle_inputs();
        check("cdb_wait0", 64'(rs_bus.dispatch_valid), 64'd0);
        tick();
        check("cdb_wait1", 64'(rs_bus.dispatch_valid), 64'd0);
        cdb(4'd2, 32'hCAFE_CAFE);
        #1;
        check("cdb_same_cycle", 64'(rs_bus.dispatch_valid), 64'd0);
        tick();
        idle_inputs();
        check("cdb_valid", 64'(rs_bus.dispatch_valid), 64'd1);
        check("cdb_tag",   64'(rs_bus.dispatch_rob_tag), 64'd5);
        check("cdb_v1",    64'(rs_bus.dispatch_v1), 64'hCAFE_CAFE);
        check("cdb_v2",    64'(rs_bus.dispatch_v2), 64'h33);
        tick();
        check("cdb_gone",  64'(rs_bus.dispatch_valid), 64'd0);

        // Issue-cycle CDB bypass on operand 2.
        issue(8'h02, 4'd6, 1'b0, 4'd0, 32'h44, 1'b1, 4'd7, 32'h0);
        cdb(4'd7, 32'hDEAD_BEEF);
        tick();
        idle_inputs();
        check("byp_valid", 64'(rs_bus.dispatch_valid), 64'd1);
        check("byp_v1",    64'(rs_bus.dispatch_v1), 64'h44);
        check("byp_v2",    64'(rs_bus.dispatch_v2), 64'hDEAD_BEEF);
        tick();
        check("byp_gone",  64'(rs_bus.dispatch_valid), 64'd0);

        // Fill all entries with pending operands (tags 12..15).
        for (int i = 0; i < 4; i++) begin
            issue(8'(i), 4'(8 + i), 1'b1, 4'(12 + i), 32'h0, 1'b0, 4'd0, 32'h55);
            tick();
        end
        idle_inputs();
        check("fill_full",  64'(rs_bus.rs_full), 64'd1);
        check("fill_valid", 64'(rs_bus.dispatch_valid), 64'd0);
        issue(8'h0F, 4'd1, 1'b0, 4'd0, 32'h66, 1'b0, 4'd0, 32'h77);
        tick();
        idle_inputs();
        check("drop_full",  64'(rs_bus.rs_full), 64'd1);
        check("drop_valid", 64'(rs_bus.dispatch_valid), 64'd0);
        cdb(4'd14, 32'h1234_5678);
        tick();
        idle_inputs();
        check("e2_valid", 64'(rs_bus.dispatch_valid), 64'd1);
        check("e2_tag",   64'(rs_bus.dispatch_rob_tag), 64'd10);
        check("e2_v1",    64'(rs_bus.dispatch_v1), 64'h1234_5678);
        check("e2_full",  64'(rs_bus.rs_full), 64'd1);
        tick();
        check("e2_freed", 64'(rs_bus.rs_full), 64'd0);
        check("e2_gone",  64'(rs_bus.dispatch_valid), 64'd0);

        // Flush with simultaneous issue and CDB capture.
        flush = 1'b1;
        issue(8'h03, 4'd2, 1'b0, 4'd0, 32'h88, 1'b0, 4'd0, 32'h99);
        cdb(4'd12, 32'hAAAA_0000);
        tick();
        flush = 1'b0;
        idle_inputs();
        check("flush_valid", 64'(rs_bus.dispatch_valid), 64'd0);
        check("flush_full",  64'(rs_bus.rs_full), 64'd0);
        cdb(4'd13, 32'h0);
        tick();
        cdb(4'd15, 32'h0);
        tick();
        idle_inputs();
        check("flush_empty", 64'(rs_bus.dispatch_valid), 64'd0);

        // Back-pressure hold, then in-order drain; issue during dispatch skips the busy slot.
        rs_bus.dispatch_ready = 1'b0;
        issue(8'h10, 4'd1, 1'b0, 4'd0, 32'h1, 1'b0, 4'd0, 32'h2);
        tick();
        issue(8'h20, 4'd4, 1'b0, 4'd0, 32'h3, 1'b0, 4'd0, 32'h4);
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", 64'(rs_bus.dispatch_valid), 64'd1);
            check("hold_tag",   64'(rs_bus.dispatch_rob_tag), 64'd1);
            tick();
        end
        rs_bus.dispatch_ready = 1'b1;
        check("drain_tag0", 64'(rs_bus.dispatch_rob_tag), 64'd1);
        issue(8'h30, 4'd7, 1'b0, 4'd0, 32'h5, 1'b0, 4'd0, 32'h6);
        tick();
        idle_inputs();
        check("drain_valid1", 64'(rs_bus.dispatch_valid), 64'd1);
        check("drain_tag1",   64'(rs_bus.dispatch_rob_tag), 64'd4);
        check("drain_ctrl1",  64'(rs_bus.dispatch_control), 64'h20);
        tick();
        check("drain_tag2",   64'(rs_bus.dispatch_rob_tag), 64'd7);
        check("drain_v1_2",   64'(rs_bus.dispatch_v1), 64'h5);
        tick();
        check("drain_empty",  64'(rs_bus.dispatch_valid), 64'd0);
        check("drain_full",   64'(rs_bus.rs_full), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
